// File: rtl/hazard_move_multi.sv
// Multi-channel hazard mover: each channel walks a position between START_POS
// and END_POS at one step per TICK_DIV clocks, in one-shot, ping-pong or loop mode.
module hazard_move_multi #(
  parameter int N_CH      = 4,
  parameter int POS_W     = 10,
  parameter int DIV_W     = 32,
  parameter int TICK_DIV  = 150000,
  parameter int START_POS = 20,
  parameter int END_POS   = 460,
  parameter int STEP      = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [N_CH-1:0]       trigger,
  input  logic [N_CH-1:0]       stop,
  input  logic [2*N_CH-1:0]     mode,
  output logic [POS_W*N_CH-1:0] pos,
  output logic [N_CH-1:0]       active,
  output logic [N_CH-1:0]       done
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MOVE, S_DONE} state_t;

  localparam logic [POS_W-1:0] START_P   = POS_W'(START_POS);
  localparam logic [POS_W-1:0] END_P     = POS_W'(END_POS);
  localparam logic [POS_W-1:0] STEP_P    = POS_W'(STEP);
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [DIV_W-1:0] cnt_q   [N_CH];
  logic [DIV_W-1:0] cnt_d   [N_CH];
  logic [POS_W-1:0] pos_q   [N_CH];
  logic [POS_W-1:0] pos_d   [N_CH];
  logic [1:0]       mode_q  [N_CH];
  logic [1:0]       mode_d  [N_CH];
  logic [N_CH-1:0]  dir_q, dir_d;   // 1 = travelling back toward START_POS
  logic [N_CH-1:0]  done_q, done_d;

  // Forward step saturating at END_POS; sum is one bit wider so it cannot wrap.
  function automatic logic [POS_W-1:0] step_fwd(input logic [POS_W-1:0] p);
    logic [POS_W:0] s;
    s = {1'b0, p} + {1'b0, STEP_P};
    if (s > {1'b0, END_P}) return END_P;
    return s[POS_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] step_rev(input logic [POS_W-1:0] p);
    if ({1'b0, p} < ({1'b0, START_P} + {1'b0, STEP_P})) return START_P;
    return p - STEP_P;
  endfunction

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pos_d[i]   = pos_q[i];
      mode_d[i]  = mode_q[i];
      dir_d[i]   = dir_q[i];
      done_d[i]  = 1'b0;
      case (state_q[i])
        S_IDLE, S_DONE: begin
          if (state_q[i] == S_IDLE) begin
            pos_d[i] = '0;
            cnt_d[i] = '0;
            dir_d[i] = 1'b0;
          end
          if (trigger[i]) begin
            state_d[i] = S_ARM;
            pos_d[i]   = START_P;
            cnt_d[i]   = '0;
            dir_d[i]   = 1'b0;
            mode_d[i]  = mode[2*i +: 2];
          end
        end
        S_ARM: begin
          state_d[i] = S_MOVE;
          cnt_d[i]   = '0;
        end
        S_MOVE: begin
          if (cnt_q[i] == TICK_LAST) begin
            cnt_d[i] = '0;
            if (!dir_q[i] && pos_q[i] == END_P) begin
              if (mode_q[i] == 2'b01) begin
                dir_d[i] = 1'b1;
                pos_d[i] = step_rev(pos_q[i]);
              end else if (mode_q[i] == 2'b10) begin
                pos_d[i] = START_P;
              end else begin
                state_d[i] = S_DONE;
                done_d[i]  = 1'b1;
              end
            end else if (!dir_q[i]) begin
              pos_d[i] = step_fwd(pos_q[i]);
            end else if (pos_q[i] == START_P) begin
              dir_d[i] = 1'b0;
              pos_d[i] = step_fwd(pos_q[i]);
            end else begin
              pos_d[i] = step_rev(pos_q[i]);
            end
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
      // Abort wins over any launch or motion in the same cycle.
      if (stop[i]) begin
        state_d[i] = S_IDLE;
        pos_d[i]   = '0;
        cnt_d[i]   = '0;
        dir_d[i]   = 1'b0;
        done_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        pos_q[i]   <= '0;
        mode_q[i]  <= 2'b00;
      end
      dir_q  <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pos_q[i]   <= pos_d[i];
        mode_q[i]  <= mode_d[i];
      end
      dir_q  <= dir_d;
      done_q <= done_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign pos[g*POS_W +: POS_W] = pos_q[g];
    assign active[g] = (state_q[g] == S_ARM) || (state_q[g] == S_MOVE);
    assign done[g]   = done_q[g];
  end

endmodule

// File: tb/tb_hazard_move_multi.sv
// Bench for hazard_move_multi: two instances (slow unit step, fast step of 7)
// compared every cycle against a time-based behavioural model, plus directed checks.
module tb_hazard_move_multi;

  localparam int SP = 20;
  localparam int EP = 460;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  trgA, stpA, trgB, stpB;
  logic [7:0]  modA, modB;
  logic [39:0] posA, posB;
  logic [3:0]  actA, actB, dnA, dnB;

  always #5 Clk = ~Clk;

  hazard_move_multi #(.N_CH(4), .POS_W(10), .DIV_W(32), .TICK_DIV(4),
    .START_POS(SP), .END_POS(EP), .STEP(1)) dutA (
    .Clk(Clk), .Reset(Reset), .trigger(trgA), .stop(stpA), .mode(modA),
    .pos(posA), .active(actA), .done(dnA));

  hazard_move_multi #(.N_CH(4), .POS_W(10), .DIV_W(32), .TICK_DIV(2),
    .START_POS(SP), .END_POS(EP), .STEP(7)) dutB (
    .Clk(Clk), .Reset(Reset), .trigger(trgB), .stop(stpB), .mode(modB),
    .pos(posB), .active(actB), .done(dnB));

  int errs = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 armed, 2 moving, 3 finished; t = cycles spent moving.
  int ph [8], p [8], t [8], rev [8], md [8];
  bit dn [8];

  int a0_done_cnt, a3_done_cnt, b0_done_cnt;
  bit a2_wrap, b0_hit_end, b0_back_start;
  logic [9:0] prev_a2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int j = 0; j < 8; j++) begin
      int td, st, k;
      logic tg, sp;
      logic [1:0] mv;
      k  = j % 4;
      td = (j < 4) ? 4 : 2;
      st = (j < 4) ? 1 : 7;
      tg = (j < 4) ? trgA[k] : trgB[k];
      sp = (j < 4) ? stpA[k] : stpB[k];
      mv = (j < 4) ? modA[2*k +: 2] : modB[2*k +: 2];
      dn[j] = 1'b0;
      if (Reset || sp) begin
        ph[j] = 0; p[j] = 0; t[j] = 0; rev[j] = 0;
      end else begin
        case (ph[j])
          0, 3: if (tg) begin
            ph[j] = 1; p[j] = SP; rev[j] = 0; md[j] = int'(mv);
          end
          1: begin ph[j] = 2; t[j] = 0; end
          default: begin
            t[j]++;
            if (t[j] % td == 0) begin
              if (rev[j] == 0 && p[j] == EP) begin
                if (md[j] == 1) begin rev[j] = 1; p[j] = (p[j] - st < SP) ? SP : p[j] - st; end
                else if (md[j] == 2) p[j] = SP;
                else begin ph[j] = 3; dn[j] = 1'b1; end
              end else if (rev[j] == 0) begin
                p[j] = (p[j] + st > EP) ? EP : p[j] + st;
              end else if (p[j] == SP) begin
                rev[j] = 0; p[j] = (p[j] + st > EP) ? EP : p[j] + st;
              end else begin
                p[j] = (p[j] - st < SP) ? SP : p[j] - st;
              end
            end
          end
        endcase
      end
    end
  endtask

  task automatic cycle();
    logic [39:0] ePA, ePB;
    logic [3:0]  eAA, eAB, eDA, eDB;
    @(posedge Clk);
    model_update();
    #1;
    for (int j = 0; j < 4; j++) begin
      ePA[10*j +: 10] = 10'(p[j]);
      ePB[10*j +: 10] = 10'(p[j+4]);
      eAA[j] = (ph[j] == 1 || ph[j] == 2);
      eAB[j] = (ph[j+4] == 1 || ph[j+4] == 2);
      eDA[j] = dn[j];
      eDB[j] = dn[j+4];
    end
    chk("posA", posA, ePA);
    chk("posB", posB, ePB);
    chk("activeA", actA, eAA);
    chk("activeB", actB, eAB);
    chk("doneA", dnA, eDA);
    chk("doneB", dnB, eDB);
    if (dnA[0]) a0_done_cnt++;
    if (dnA[3]) a3_done_cnt++;
    if (dnB[0]) b0_done_cnt++;
    if (prev_a2 == 10'(EP) && posA[29:20] == 10'(SP) && actA[2]) a2_wrap = 1'b1;
    prev_a2 = posA[29:20];
    if (posB[9:0] == 10'(EP)) b0_hit_end = 1'b1;
    if (b0_hit_end && actB[0] && posB[9:0] == 10'(SP)) b0_back_start = 1'b1;
  endtask

  initial begin
    for (int j = 0; j < 8; j++) begin
      ph[j] = 0; p[j] = 0; t[j] = 0; rev[j] = 0; md[j] = 0; dn[j] = 1'b0;
    end
    a0_done_cnt = 0; a3_done_cnt = 0; b0_done_cnt = 0;
    a2_wrap = 1'b0; b0_hit_end = 1'b0; b0_back_start = 1'b0; prev_a2 = '0;
    Reset = 1'b1; trgA = '0; stpA = '0; trgB = '0; stpB = '0; modA = '0; modB = '0;
    repeat (2) cycle();
    chk("reset_pos", {posA, posB}, 80'd0);
    chk("reset_act_done", {actA, actB, dnA, dnB}, 16'd0);
    Reset = 1'b0;
    cycle();

    // stop and trigger together on an idle channel
    trgA = 4'b0010; stpA = 4'b0010;
    cycle();
    trgA = '0; stpA = '0;
    chk("stop_trig_pos1", posA[19:10], 10'd0);
    chk("stop_trig_act1", actA[1], 1'b0);
    cycle();
    chk("stop_trig_act1_later", actA[1], 1'b0);

    // ch0 one-shot, ch2 loop, ch3 ping-pong (later); B ch0 ping-pong
    modA = {2'b01, 2'b10, 2'b00, 2'b00};
    modB = 8'b00_00_00_01;
    trgA = 4'b0101; trgB = 4'b0001;
    cycle();
    trgA = '0; trgB = '0;
    chk("arm_pos0", posA[9:0], 10'd20);
    chk("arm_act0", actA[0], 1'b1);
    cycle();
    chk("move_entry_pos0", posA[9:0], 10'd20);
    repeat (3) cycle();
    chk("before_first_step", posA[9:0], 10'd20);
    cycle();
    chk("first_step", posA[9:0], 10'd21);
    trgA = 4'b1001;
    cycle();
    trgA = '0;
    modA = 8'hFF;
    repeat (1800) cycle();
    chk("a0_done_once", a0_done_cnt, 1);
    chk("a0_hold_end", posA[9:0], 10'd460);
    chk("a0_inactive", actA[0], 1'b0);
    chk("a2_wrapped", a2_wrap, 1'b1);
    chk("a2_still_active", actA[2], 1'b1);
    chk("a3_no_done", a3_done_cnt, 0);
    chk("a3_active", actA[3], 1'b1);
    chk("b0_reached_end", b0_hit_end, 1'b1);
    chk("b0_back_to_start", b0_back_start, 1'b1);
    chk("b0_no_done", b0_done_cnt, 0);

    // abort mid-motion
    stpA = 4'b1000;
    cycle();
    stpA = '0;
    chk("stop_pos3", posA[39:30], 10'd0);
    chk("stop_act3", actA[3], 1'b0);

    // launch everything, then reset mid-motion
    modA = 8'b01_10_00_11; modB = 8'b10_01_00_01;
    trgA = 4'hF; trgB = 4'hF;
    cycle();
    trgA = '0; trgB = '0;
    repeat (20) cycle();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    chk("midreset_pos", {posA, posB}, 80'd0);
    chk("midreset_act_done", {actA, actB, dnA, dnB}, 16'd0);
    trgA = 4'b0001;
    cycle();
    trgA = '0;
    chk("retrigger_pos", posA[9:0], 10'd20);
    chk("retrigger_act", actA[0], 1'b1);
    repeat (10) cycle();

    // randomized traffic against the model
    repeat (4000) begin
      trgA = 4'($urandom & $urandom & $urandom);
      trgB = 4'($urandom & $urandom & $urandom);
      stpA = 4'($urandom & $urandom & $urandom & $urandom & $urandom);
      stpB = 4'($urandom & $urandom & $urandom & $urandom & $urandom);
      modA = 8'($urandom);
      modB = 8'($urandom);
      Reset = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hazard_move_multi.md
HAZARD_MOVE_MULTI -- requirements
Module: hazard_move_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent hazard channels.
REQ-002 Parameter POS_W, default 10, position width in pixels.
REQ-003 Parameter DIV_W, default 32, tick-divider counter width.
REQ-004 Parameter TICK_DIV, default 150000, clocks per position step; legal range 1..2^DIV_W-1.
REQ-005 Parameter START_POS, default 20, position loaded on launch.
REQ-006 Parameter END_POS, default 460, far travel limit; START_POS < END_POS < 2^POS_W.
REQ-007 Parameter STEP, default 1, pixels per step; 1 <= STEP <= END_POS-START_POS.
REQ-008 Clk  input  1  system clock; all logic on rising edge.
REQ-009 Reset  input  1  synchronous, active-high reset.
REQ-010 trigger  input  N_CH  per-channel launch request, level-sampled.
REQ-011 stop  input  N_CH  per-channel abort to IDLE.
REQ-012 mode  input  2*N_CH  per-channel mode: 00 one-shot, 01 ping-pong, 10 loop, 11 reserved (behaves as one-shot).
REQ-013 pos  output  POS_W*N_CH  channel i position at bits [i*POS_W +: POS_W].
REQ-014 active  output  N_CH  high while channel is in ARM or MOVE.
REQ-015 done  output  N_CH  one-cycle pulse when a one-shot channel reaches END_POS.

Function
REQ-016 Each channel SHALL contain its own FSM {IDLE, ARM, MOVE, DONE}, divider counter (DIV_W), position register (POS_W) and direction bit; channels SHALL NOT interact.
REQ-017 IDLE: pos=0, counter=0, dir=forward; trigger[i]=1 -> ARM next cycle.
REQ-018 ARM: lasts exactly one cycle; pos loaded to START_POS, counter=0, dir=forward, mode[i] latched; -> MOVE.
REQ-019 MOVE: counter increments each cycle; when counter==TICK_DIV-1 it SHALL clear to 0 and pos SHALL advance by STEP (forward: +STEP, reverse: -STEP) in the same cycle.
REQ-020 First step SHALL appear on pos exactly TICK_DIV cycles after the cycle in which the channel enters MOVE.
REQ-021 Forward overshoot: if pos+STEP > END_POS the step SHALL clamp pos to END_POS; reverse undershoot SHALL clamp to START_POS.
REQ-022 In MOVE with pos==END_POS and dir forward, on the next step boundary: one-shot -> DONE with done[i] pulsed for one cycle; ping-pong -> dir reverses and pos steps toward START_POS; loop -> pos reloads START_POS.
REQ-023 Ping-pong with pos==START_POS and dir reverse, at step boundary: dir forward, pos steps away from START_POS; no done pulse.
REQ-024 DONE: pos holds END_POS, counter holds; trigger[i]=1 -> ARM (relaunch).
REQ-025 trigger while in ARM or MOVE SHALL be ignored; latched mode SHALL NOT change until next ARM.
REQ-026 stop[i]=1 in any state SHALL force IDLE next cycle (pos=0, counter=0); stop has priority over trigger in the same cycle.
REQ-027 All arithmetic unsigned; no pos value outside [START_POS, END_POS] SHALL occur outside IDLE.
REQ-028 Outputs SHALL be registered; active and done derived from registered state only.

Reset
REQ-029 Reset=1 SHALL force every channel to IDLE, pos=0, counter=0, dir=forward, active=0, done=0 on the next rising edge, overriding trigger and stop.
REQ-030 Reset asserted mid-MOVE SHALL abort motion with no done pulse.

Verification
REQ-031 TICK_DIV=4, one-shot, trigger ch0 one cycle -> ARM pos=20, pos=21 four cycles after MOVE entry, pos=460 then done[0] single pulse, pos holds 460.
REQ-032 Ping-pong, STEP=7, TICK_DIV=2 -> pos clamps to 460, reverses, clamps to 20, resumes forward; done never asserts.
REQ-033 Loop mode -> after pos=460, next step pos=20, active stays 1.
REQ-034 stop and trigger same cycle on ch1 in IDLE -> ch1 stays IDLE, pos=0; stop mid-MOVE -> pos=0, active=0 next cycle.
REQ-035 Ch0 one-shot and ch3 ping-pong launched on different cycles -> independent positions; ch3 unaffected by ch0 done.
REQ-036 Reset during MOVE of all channels -> all pos=0, active=0, done=0 next cycle; retrigger works normally.
